parking_gate_arbiter: RTL and testbench

- Arbitrates a single shared one-lane gate between an entry queue and an exit queue of the parking lot.
- Grants one lane at a time, holds the grant until the sensor-sequence decoder reports the car has passed, then updates the lot occupancy.
- Blocks entry when the lot is full and recovers from stalled cars by timeout.
- Sits between the lane request detectors / A-B sensor decoder and the gate actuators and occupancy display driver.

---
 rtl/parking_gate_arbiter.sv | 134 +++++++++++++
 tb/tb_parking_gate_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_arbiter.sv
// Shares one gate between the entry and exit lanes: round-robin grant, hold until the
// car clears or the timer expires, then a one-cycle closed guard before the next grant.
module parking_gate_arbiter #(
   parameter int CAPACITY       = 99,
   parameter int COUNT_W        = 7,
   parameter int TIMEOUT_CYCLES = 500000000
) (
   input  logic               CLK100MHZ,
   input  logic               reset,
   input  logic               entry_req,
   input  logic               exit_req,
   input  logic               car_passed,
   output logic               entry_grant,
   output logic               exit_grant,
   output logic [COUNT_W-1:0] occupancy,
   output logic               full,
   output logic               empty,
   output logic               timeout_pulse,
   output logic               busy
);

   localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [COUNT_W-1:0] OCC_MAX    = COUNT_W'(CAPACITY);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_GRANT_IN  = 2'd1;
   localparam logic [1:0] ST_GRANT_OUT = 2'd2;
   localparam logic [1:0] ST_GAP       = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [COUNT_W-1:0] occ_q, occ_d;
   logic               last_exit_q, last_exit_d;
   logic               entry_grant_q, entry_grant_d;
   logic               exit_grant_q, exit_grant_d;
   logic               full_q, full_d;
   logic               empty_q, empty_d;
   logic               timeout_q, timeout_d;
   logic               busy_q, busy_d;
   logic               entry_ok, exit_ok;

   assign entry_ok = entry_req && !full_q;
   assign exit_ok  = exit_req;

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      occ_d       = occ_q;
      last_exit_d = last_exit_q;
      timeout_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            if (entry_ok && exit_ok) begin
               state_d = last_exit_q ? ST_GRANT_IN : ST_GRANT_OUT;
            end else if (entry_ok) begin
               state_d = ST_GRANT_IN;
            end else if (exit_ok) begin
               state_d = ST_GRANT_OUT;
            end
         end
         ST_GRANT_IN, ST_GRANT_OUT: begin
            // A pass on the expiry cycle still counts as a pass.
            if (car_passed) begin
               state_d     = ST_GAP;
               last_exit_d = (state_q == ST_GRANT_OUT);
               if (state_q == ST_GRANT_IN) begin
                  if (occ_q != OCC_MAX) occ_d = occ_q + 1'b1;
               end else begin
                  if (occ_q != '0) occ_d = occ_q - 1'b1;
               end
            end else if (timer_q == TIMER_LAST) begin
               state_d     = ST_GAP;
               last_exit_d = (state_q == ST_GRANT_OUT);
               timeout_d   = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_GAP: begin
            timer_d = '0;
            state_d = ST_IDLE;
         end
         default: begin
            timer_d = '0;
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are precomputed from the next state so every one of them is a flop.
      entry_grant_d = (state_d == ST_GRANT_IN);
      exit_grant_d  = (state_d == ST_GRANT_OUT);
      busy_d        = (state_d != ST_IDLE);
      full_d        = (occ_d == OCC_MAX);
      empty_d       = (occ_d == '0);
   end

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         timer_q       <= '0;
         occ_q         <= '0;
         last_exit_q   <= 1'b1;
         entry_grant_q <= 1'b0;
         exit_grant_q  <= 1'b0;
         full_q        <= 1'b0;
         empty_q       <= 1'b1;
         timeout_q     <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         occ_q         <= occ_d;
         last_exit_q   <= last_exit_d;
         entry_grant_q <= entry_grant_d;
         exit_grant_q  <= exit_grant_d;
         full_q        <= full_d;
         empty_q       <= empty_d;
         timeout_q     <= timeout_d;
         busy_q        <= busy_d;
      end
   end

   assign entry_grant   = entry_grant_q;
   assign exit_grant    = exit_grant_q;
   assign occupancy     = occ_q;
   assign full          = full_q;
   assign empty         = empty_q;
   assign timeout_pulse = timeout_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Bench for parking_gate_arbiter: lane-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_parking_gate_arbiter;

   localparam int CAP = 3;
   localparam int TO  = 16;
   localparam int CW  = 7;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          entry_req = 1'b0;
   logic          exit_req = 1'b0;
   logic          car_passed = 1'b0;
   logic          entry_grant, exit_grant, full, empty, timeout_pulse, busy;
   logic [CW-1:0] occupancy;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   parking_gate_arbiter #(.CAPACITY(CAP), .COUNT_W(CW), .TIMEOUT_CYCLES(TO)) dut (
      .CLK100MHZ    (clk),
      .reset        (reset),
      .entry_req    (entry_req),
      .exit_req     (exit_req),
      .car_passed   (car_passed),
      .entry_grant  (entry_grant),
      .exit_grant   (exit_grant),
      .occupancy    (occupancy),
      .full         (full),
      .empty        (empty),
      .timeout_pulse(timeout_pulse),
      .busy         (busy)
   );

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: which lane holds the gate (0 none, 1 entry, 2 exit), how long it
   // has held it, whether the closed guard cycle is in progress, and the car count.
   typedef struct packed {
      int lane;
      int held;
      bit gap;
      bit to;
      int occ;
      int last;
   } mstate_t;

   mstate_t m;

   function automatic mstate_t model_reset();
      mstate_t n;
      n.lane = 0; n.held = 0; n.gap = 1'b0; n.to = 1'b0; n.occ = 0; n.last = 2;
      return n;
   endfunction

   function automatic mstate_t model_step(mstate_t s, logic ereq, logic xreq, logic cp);
      mstate_t n;
      bit in_ok;
      n = s;
      n.to = 1'b0;
      if (s.gap) begin
         n.gap = 1'b0;
      end else if (s.lane != 0) begin
         n.held = s.held + 1;
         if (cp) begin
            if (s.lane == 1) n.occ = (s.occ < CAP) ? s.occ + 1 : s.occ;
            else             n.occ = (s.occ > 0) ? s.occ - 1 : 0;
            n.last = s.lane; n.lane = 0; n.gap = 1'b1;
         end else if (n.held == TO) begin
            n.to = 1'b1; n.last = s.lane; n.lane = 0; n.gap = 1'b1;
         end
      end else begin
         in_ok  = ereq && (s.occ < CAP);
         n.held = 0;
         if (in_ok && xreq) n.lane = (s.last == 1) ? 2 : 1;
         else if (in_ok)    n.lane = 1;
         else if (xreq)     n.lane = 2;
      end
      return n;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) m <= model_reset();
      else       m <= model_step(m, entry_req, exit_req, car_passed);
   end

   always @(negedge clk) begin
      check("entry_grant", int'(entry_grant), int'(m.lane == 1));
      check("exit_grant", int'(exit_grant), int'(m.lane == 2));
      check("occupancy", int'(occupancy), m.occ);
      check("full", int'(full), int'(m.occ == CAP));
      check("empty", int'(empty), int'(m.occ == 0));
      check("timeout_pulse", int'(timeout_pulse), int'(m.to));
      check("busy", int'(busy), int'(m.lane != 0 || m.gap));
      check("grant_exclusive", int'(entry_grant && exit_grant), 0);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      entry_req = 1'b0; exit_req = 1'b0; car_passed = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      tick(1);
   endtask

   task automatic wait_grant(input int lane);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if ((lane == 1) ? entry_grant : exit_grant) seen = 1'b1;
      end
      if (!seen) check("wait_grant_timeout", 0, lane);
   endtask

   // Request a lane, wait for its grant, pass one car, and come back to an idle gate.
   task automatic serve(input int lane);
      if (lane == 1) entry_req = 1'b1; else exit_req = 1'b1;
      wait_grant(lane);
      entry_req = 1'b0; exit_req = 1'b0;
      car_passed = 1'b1;
      tick(1);
      car_passed = 1'b0;
      tick(2);
   endtask

   initial begin
      int seen;
      int g_cnt, t_cnt, x_seen;
      int order[4];

      tick(3);
      reset = 1'b0;
      tick(1);
      check("rst_occupancy", int'(occupancy), 0);
      check("rst_empty", int'(empty), 1);
      check("rst_busy", int'(busy), 0);

      // First entry: 1-cycle grant latency, count 0 -> 1.
      entry_req = 1'b1;
      tick(1);
      check("t1_entry_latency", int'(entry_grant), 1);
      entry_req = 1'b0;
      tick(2);
      car_passed = 1'b1;
      tick(1);
      car_passed = 1'b0;
      check("t1_grant_fall", int'(entry_grant), 0);
      check("t1_occupancy", int'(occupancy), 1);
      check("t1_empty", int'(empty), 0);
      tick(1);

      // Fill to capacity, then a waiting entry must only follow an exit.
      serve(1);
      serve(1);
      check("t2_full", int'(full), 1);
      check("t2_occ3", int'(occupancy), 3);
      entry_req = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         if (entry_grant) seen++;
      end
      check("t2_full_blocks_entry", seen, 0);
      exit_req = 1'b1;
      wait_grant(2);
      exit_req = 1'b0;
      car_passed = 1'b1;
      tick(1);
      car_passed = 1'b0;
      check("t2_occ_after_exit", int'(occupancy), 2);
      check("t2_gap_closed", int'(entry_grant), 0);
      tick(1);
      check("t2_idle_closed", int'(entry_grant), 0);
      tick(1);
      check("t2_pending_entry", int'(entry_grant), 1);
      entry_req = 1'b0;
      car_passed = 1'b1;
      tick(1);
      car_passed = 1'b0;
      check("t2_occ_refull", int'(occupancy), 3);
      tick(2);

      // Round robin with both lanes always requesting.
      do_reset();
      entry_req = 1'b1;
      exit_req  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         order[k] = 0;
         for (int i = 0; i < 60 && order[k] == 0; i++) begin
            tick(1);
            if (entry_grant) order[k] = 1;
            else if (exit_grant) order[k] = 2;
         end
         car_passed = 1'b1;
         tick(1);
         car_passed = 1'b0;
         check("t3_gap", int'(entry_grant || exit_grant), 0);
      end
      check("t3_order0", order[0], 1);
      check("t3_order1", order[1], 2);
      check("t3_order2", order[2], 1);
      check("t3_order3", order[3], 2);
      entry_req = 1'b0;
      exit_req  = 1'b0;
      tick(3);
      check("t3_occupancy", int'(occupancy), 0);

      // Timeout: entry held without a pass, exit waiting behind it.
      do_reset();
      entry_req = 1'b1;
      exit_req  = 1'b1;
      g_cnt = 0; t_cnt = 0; x_seen = 0;
      for (int i = 0; i < 60 && x_seen == 0; i++) begin
         tick(1);
         if (entry_grant)   g_cnt++;
         if (timeout_pulse) t_cnt++;
         if (exit_grant)    x_seen = 1;
      end
      check("t4_grant_cycles", g_cnt, 16);
      check("t4_timeout_width", t_cnt, 1);
      check("t4_exit_next", x_seen, 1);
      check("t4_occupancy", int'(occupancy), 0);
      entry_req = 1'b0;
      exit_req  = 1'b0;
      car_passed = 1'b1;
      tick(1);
      car_passed = 1'b0;
      tick(2);

      // Asynchronous reset in the middle of an exit grant.
      serve(1);
      serve(1);
      serve(1);
      exit_req = 1'b1;
      wait_grant(2);
      #2 reset = 1'b1;
      #1;
      check("t5_async_grant", int'(exit_grant), 0);
      check("t5_async_occ", int'(occupancy), 0);
      check("t5_async_busy", int'(busy), 0);
      exit_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      tick(1);
      check("t5_idle_after", int'(busy), 0);

      // Exit at empty and a stray pass while idle.
      exit_req = 1'b1;
      wait_grant(2);
      exit_req = 1'b0;
      car_passed = 1'b1;
      tick(1);
      car_passed = 1'b0;
      check("t6_occ_floor", int'(occupancy), 0);
      tick(3);
      car_passed = 1'b1;
      tick(1);
      car_passed = 1'b0;
      check("t6_stray_busy", int'(busy), 0);
      check("t6_stray_occ", int'(occupancy), 0);
      tick(1);

      // Random traffic, occasionally resetting mid-flight.
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 999) == 0) begin
            #2 reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end
         entry_req  = ($urandom_range(0, 99) < 45);
         exit_req   = ($urandom_range(0, 99) < 35);
         car_passed = ($urandom_range(0, 99) < 12);
      end
      entry_req = 1'b0; exit_req = 1'b0; car_passed = 1'b0;
      tick(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
